// File: rtl/gpu_decode_issue_pkg.sv
// Shared GPU ISA definitions: unit classes, instruction field positions and opcode decode helpers.
package gpu_opcodes;

    typedef enum logic [3:0] {
        UNIT_NOP        = 4'd0,
        UNIT_INT_ALU    = 4'd1,
        UNIT_INT_MUL    = 4'd2,
        UNIT_INT_DIV    = 4'd3,
        UNIT_FP_ADD     = 4'd4,
        UNIT_FP_MUL     = 4'd5,
        UNIT_FP_DIVSQRT = 4'd6,
        UNIT_FP_CVT     = 4'd7,
        UNIT_ILLEGAL    = 4'd8
    } gpu_unit_e;

    localparam int OPC_LSB     = 24;
    localparam int RD_LSB      = 19;
    localparam int RS1_LSB     = 14;
    localparam int RS2_LSB     = 9;
    localparam int RS3_LSB     = 4;
    localparam int IMM_W       = 14;
    localparam int REG_FIELD_W = 5;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic use_rs3;
        logic use_imm;
        logic writes_rd;
    } gpu_ops_t;

    function automatic gpu_unit_e decode_unit(input logic [7:0] op);
        gpu_unit_e u;
        case (op) inside
            8'h01, 8'h02, 8'h05, 8'h06, 8'h10, 8'h11, [8'h20:8'h24], [8'h30:8'h34],
            [8'h40:8'h49], [8'h60:8'h63], [8'h70:8'h74], 8'h80, 8'h81, 8'h90, 8'h91:
                u = UNIT_INT_ALU;
            8'h03, 8'h12, 8'h92:                               u = UNIT_INT_MUL;
            8'h04:                                             u = UNIT_INT_DIV;
            8'hA0, 8'hA1, 8'hA4, 8'hA5, 8'hAA, 8'hAB, [8'hB0:8'hB5]:
                u = UNIT_FP_ADD;
            8'hA2, 8'hA9:                                      u = UNIT_FP_MUL;
            8'hA3, 8'hA6, 8'hA7, 8'hA8:                        u = UNIT_FP_DIVSQRT;
            8'hAC, 8'hAD:                                      u = UNIT_FP_CVT;
            8'h9F:                                             u = UNIT_NOP;
            default:                                           u = UNIT_ILLEGAL;
        endcase
        return u;
    endfunction

    function automatic gpu_ops_t decode_operands(input logic [7:0] op);
        gpu_ops_t  o;
        gpu_unit_e u;
        u = decode_unit(op);
        o = '0;
        if (u != UNIT_NOP && u != UNIT_ILLEGAL) begin
            o.use_rs1   = 1'b1;
            o.writes_rd = 1'b1;
            case (op) inside
                8'h05, 8'h06, 8'h23, [8'h70:8'h73], [8'hA4:8'hA8], 8'hAC, 8'hAD: ;
                8'h10, 8'h11, 8'h12: o.use_imm = 1'b1;
                8'hA9: begin
                    o.use_rs2 = 1'b1;
                    o.use_rs3 = 1'b1;
                end
                default: o.use_rs2 = 1'b1;
            endcase
        end
        return o;
    endfunction

endpackage

// File: rtl/gpu_decode_issue_scoreboard.sv
// Pending-destination scoreboard with RAW/WAW hazard compare.
// GPU_SB_WB_BYPASS_EN: hazard check ignores the register being written back this cycle.
module gpu_scoreboard
    import gpu_opcodes::*;
#(
    parameter int NUM_REGS = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_set_en,
    input  logic [REG_FIELD_W-1:0] i_set_rd,
    input  logic                   i_wb_valid,
    input  logic [REG_FIELD_W-1:0] i_wb_rd,
    input  logic                   i_clr_en,
    input  logic [REG_FIELD_W-1:0] i_clr_rd,
    input  logic                   i_use_rs1,
    input  logic                   i_use_rs2,
    input  logic                   i_use_rs3,
    input  logic                   i_use_rd,
    input  logic [REG_FIELD_W-1:0] i_rs1,
    input  logic [REG_FIELD_W-1:0] i_rs2,
    input  logic [REG_FIELD_W-1:0] i_rs3,
    input  logic [REG_FIELD_W-1:0] i_rd,
    output logic                   o_hazard,
    output logic [NUM_REGS-1:0]    o_pending
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_next;
    logic [NUM_REGS-1:0] w_view;
    logic [31:0]         w_ext;

    // Indices beyond NUM_REGS shift out; bit 0 is masked so r0 is never pending.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [REG_FIELD_W-1:0] idx);
        return (NUM_REGS'(1) << idx) & ~NUM_REGS'(1);
    endfunction

    always_comb begin
        w_set = i_set_en ? onehot(i_set_rd) : '0;
        w_clr = '0;
        if (i_wb_valid) w_clr = w_clr | onehot(i_wb_rd);
        if (i_clr_en)   w_clr = w_clr | onehot(i_clr_rd);
        w_next = (r_pending & ~w_clr) | w_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pending <= '0;
        else        r_pending <= w_next;
    end

    always_comb begin
`ifdef GPU_SB_WB_BYPASS_EN
        w_view = r_pending & ~(i_wb_valid ? onehot(i_wb_rd) : '0);
`else
        w_view = r_pending;
`endif
        w_ext    = 32'(w_view);
        o_hazard = (i_use_rs1 & w_ext[i_rs1]) | (i_use_rs2 & w_ext[i_rs2]) |
                   (i_use_rs3 & w_ext[i_rs3]) | (i_use_rd  & w_ext[i_rd]);
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/gpu_decode_issue.sv
// Decode-and-issue stage: opcode decode, scoreboard hazard hold-off, registered valid/ready output.
// GPU_SB_WB_BYPASS_EN (in gpu_scoreboard) lets a dependent instruction issue in its writeback cycle.
module gpu_decode_issue
    import gpu_opcodes::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_instr,
    input  logic                wb_valid,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_opcode,
    output logic [3:0]          out_unit,
    output logic [REG_AW-1:0]   out_rd,
    output logic [REG_AW-1:0]   out_rs1,
    output logic [REG_AW-1:0]   out_rs2,
    output logic [REG_AW-1:0]   out_rs3,
    output logic [DATA_W-1:0]   out_imm,
    output logic                out_use_rs2,
    output logic                out_use_rs3,
    output logic                out_use_imm,
    output logic                out_writes_rd,
    output logic                out_illegal,
    output logic [NUM_REGS-1:0] sb_pending
);

    logic [7:0]        w_opc;
    logic [REG_AW-1:0] w_rd, w_rs1, w_rs2, w_rs3;
    gpu_unit_e         w_unit;
    gpu_ops_t          w_ops;
    logic              w_oob, w_illegal, w_hazard, w_accept, w_sets_sb;

    logic              r_valid, r_sets_sb;
    logic [7:0]        r_opc;
    gpu_unit_e         r_unit;
    logic [REG_AW-1:0] r_rd, r_rs1, r_rs2, r_rs3;
    logic [DATA_W-1:0] r_imm;
    gpu_ops_t          r_ops;
    logic              r_ill;

    assign w_opc  = in_instr[OPC_LSB +: 8];
    assign w_rd   = in_instr[RD_LSB  +: REG_AW];
    assign w_rs1  = in_instr[RS1_LSB +: REG_AW];
    assign w_rs2  = in_instr[RS2_LSB +: REG_AW];
    assign w_rs3  = in_instr[RS3_LSB +: REG_AW];
    assign w_unit = decode_unit(w_opc);
    assign w_ops  = decode_operands(w_opc);

    // Only fields the opcode actually uses can make it illegal through range.
    assign w_oob = (w_ops.use_rs1   && 32'(w_rs1) >= NUM_REGS) ||
                   (w_ops.use_rs2   && 32'(w_rs2) >= NUM_REGS) ||
                   (w_ops.use_rs3   && 32'(w_rs3) >= NUM_REGS) ||
                   (w_ops.writes_rd && 32'(w_rd)  >= NUM_REGS);

    assign w_illegal = (w_unit == UNIT_ILLEGAL) || w_oob;
    assign w_sets_sb = w_ops.writes_rd && (w_rd != '0) && !w_illegal;
    assign in_ready  = (!r_valid || out_ready) && !w_hazard && !flush;
    assign w_accept  = in_valid && in_ready;

    gpu_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_set_en   (w_accept && w_sets_sb),
        .i_set_rd   (w_rd),
        .i_wb_valid (wb_valid),
        .i_wb_rd    (wb_rd),
        .i_clr_en   (flush && r_valid && r_sets_sb),
        .i_clr_rd   (r_rd),
        .i_use_rs1  (w_ops.use_rs1),
        .i_use_rs2  (w_ops.use_rs2),
        .i_use_rs3  (w_ops.use_rs3),
        .i_use_rd   (w_ops.writes_rd),
        .i_rs1      (w_rs1),
        .i_rs2      (w_rs2),
        .i_rs3      (w_rs3),
        .i_rd       (w_rd),
        .o_hazard   (w_hazard),
        .o_pending  (sb_pending)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_sets_sb <= 1'b0;
            r_opc     <= '0;
            r_unit    <= UNIT_NOP;
            r_rd      <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rs3     <= '0;
            r_imm     <= '0;
            r_ops     <= '0;
            r_ill     <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_sets_sb <= w_sets_sb;
            r_opc     <= w_opc;
            r_unit    <= w_unit;
            r_rd      <= w_rd;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rs3     <= w_rs3;
            r_imm     <= DATA_W'($signed(in_instr[IMM_W-1:0]));
            r_ops     <= w_ops;
            r_ill     <= w_illegal;
        end else if (flush || out_ready) begin
            r_valid   <= 1'b0;
            r_sets_sb <= 1'b0;
        end
    end

    assign out_valid     = r_valid;
    assign out_opcode    = r_opc;
    assign out_unit      = r_unit;
    assign out_rd        = r_rd;
    assign out_rs1       = r_rs1;
    assign out_rs2       = r_rs2;
    assign out_rs3       = r_rs3;
    assign out_imm       = r_imm;
    assign out_use_rs2   = r_ops.use_rs2;
    assign out_use_rs3   = r_ops.use_rs3;
    assign out_use_imm   = r_ops.use_imm;
    assign out_writes_rd = r_ops.writes_rd;
    assign out_illegal   = r_ill;

endmodule

// File: doc/gpu_decode_issue.md
Name: gpu_decode_issue

Overview:
- Parametrised decode-and-issue stage for the GPU ISA, sitting between instruction fetch and the integer/FP execution units.
- Decodes the 8-bit opcode into a functional-unit class, operand-usage flags and a sign-extended immediate.
- Tracks pending destination registers in a scoreboard and holds back instructions with RAW/WAW hazards.
- Presents one decoded instruction per cycle on a registered valid/ready output.

Parameters:
- NUM_REGS, 32, architectural registers per thread; power of two, 2..32.
- DATA_W, 32, width of out_imm; must be at least 14.
- REG_AW, 5, register field width in the instruction; fixed at 5, do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch has an instruction
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  32  fields: opcode[31:24] rd[23:19] rs1[18:14] rs2[13:9] rs3[8:4] imm14[13:0]
- wb_valid  in  1  an execution unit retires a write
- wb_rd  in  5  register being retired
- flush  in  1  discard the held output instruction
- out_valid  out  1  decoded instruction held
- out_ready  in  1  execution side accepts
- out_opcode  out  8  registered opcode
- out_unit  out  4  unit class (package enum)
- out_rd, out_rs1, out_rs2, out_rs3  out  5 each  register fields
- out_imm  out  DATA_W  imm14 sign-extended
- out_use_rs2, out_use_rs3, out_use_imm, out_writes_rd  out  1 each  operand flags
- out_illegal  out  1  undefined opcode, or register index >= NUM_REGS
- sb_pending  out  NUM_REGS  scoreboard state

Behaviour:
- Reset: all outputs and scoreboard are 0; out_unit = UNIT_NOP. in_ready follows combinationally.
- Unit classes:
  - INT_ALU: 0x01,02,05,06,10,11,20-24,30-34,40-49,60-63,70-74,80,81,90,91
  - INT_MUL: 0x03,12,92
  - INT_DIV: 0x04
  - FP_ADD: A0,A1,A4,A5,AA,AB,B0-B5
  - FP_MUL: A2,A9
  - FP_DIVSQRT: A3,A6,A7,A8
  - FP_CVT: AC,AD
  - NOP: 9F
  - ILLEGAL: every other opcode
- Operand use:
  - Unary ops (05,06,23,70-73,A4-A8,AC,AD) read rs1 only.
  - I-type (10,11,12) read rs1 and set out_use_imm.
  - A9 (FMA) reads rs1, rs2 and rs3.
  - Other legal non-NOP ops read rs1 and rs2.
  - All legal non-NOP ops set out_writes_rd.
- Hazard: asserted when any used source, or rd (WAW), has its sb_pending bit set. Register 0 is never pending and never causes a hazard.
- in_ready = (!out_valid | out_ready) & !hazard & !flush.
- Accept (in_valid & in_ready):
  - Output register loads on the next edge; latency is 1 cycle.
  - If out_writes_rd, rd != 0 and not illegal: sb_pending[rd] sets on the same edge.
- NOP and illegal instructions never touch the scoreboard. Illegal instructions are still issued with out_illegal=1 so the trap logic downstream sees them.
- Writeback: wb_valid clears sb_pending[wb_rd] on the next edge. If the same register is set and cleared in one cycle, set wins. wb_rd=0 is ignored.
- Flush:
  - out_valid clears on the next edge.
  - If the held instruction set a scoreboard bit, that bit clears, unless wb_valid targets the same register in the same cycle (clear either way).
  - A flush in the same cycle as out_ready: the flush wins and the instruction is not counted as issued.
- Output stability: while out_valid & !out_ready, all out_* fields hold.
- Back-to-back: full throughput when there are no hazards.
- Reset mid-operation: scoreboard and output are cleared immediately (asynchronous).

Optional Feature:
- GPU_SB_WB_BYPASS_EN
- Defined: the hazard check ignores the register named by a same-cycle wb_valid/wb_rd, so a dependent instruction issues in the writeback cycle.
- Undefined: the clear becomes visible one cycle later, so a dependent instruction issues one cycle after the writeback.

Decomposition:
- Add to the shared package gpu_opcodes:
  - enum gpu_unit_e (4-bit)
  - instruction field position constants
  - IMM_W=14
  - function decode_unit(opcode)
  - function decode_operands(opcode)
- One sub-module, gpu_scoreboard: a NUM_REGS-bit set/clear/flush register file with the hazard compare, including the bypass option.

Test Plan:
- Decode test: issue 0x10187FFF (ADD_I r3,r1,-1) -> next cycle out_unit=INT_ALU, out_imm=0xFFFFFFFF, out_use_imm=1, sb_pending[3]=1.
- RAW stall: issue 0x01284400 (ADD r5,r1,r2), then 0x02314200 (SUB r6,r5,r1).
  - in_ready=0 until wb_valid with wb_rd=5.
  - SUB is accepted 1 cycle after the writeback without bypass, and in the same cycle with GPU_SB_WB_BYPASS_EN defined.
- Back-pressure: hold out_ready=0 for 4 cycles with in_valid=1 -> out_* stable and in_ready=0; release -> one instruction issues per cycle.
- Illegal/NOP: opcode 0xFF -> out_illegal=1 and scoreboard unchanged. Opcode 0x9F -> out_unit=NOP and no scoreboard bit set. An instruction with rd=0 never sets sb_pending.
- Flush: a held ADD with rd=7 stalled by out_ready=0, then flush=1 -> out_valid=0 and sb_pending[7]=0 next cycle. A same-cycle in_valid is not accepted.
- Reset: assert rst_n=0 mid-stall -> out_valid=0 and sb_pending=0 immediately, without waiting for a clock edge.
